// File: rtl/tx_poly_upsmp_pkg.sv
// Shared constants for the TX polyphase upsampler and the matching RX blocks.
// Holds default sizes, the raised-cosine coefficient set and index helpers.
package tx_poly_upsmp_pkg;

   localparam int DEF_OS     = 4;
   localparam int DEF_TAPS   = 6;
   localparam int DEF_S_IN   = 2;
   localparam int DEF_S_COEF = 8;
   localparam int DEF_FASE   = $clog2(DEF_OS);
   localparam int DEF_S_OUT  = DEF_S_COEF + DEF_S_IN + $clog2(DEF_TAPS);
   localparam int DEF_NCOEF  = DEF_OS * DEF_TAPS;
   localparam int DEF_COEF_W = DEF_NCOEF * DEF_S_COEF;

   // Coefficient h[k*OS+p] feeds symbol tap k in polyphase branch p.
   function automatic int coef_idx(input int k, input int p, input int os);
      return k * os + p;
   endfunction

   // Raised cosine, roll-off 0.5, Q7, symmetric about the filter centre.
   function automatic int rc_tap(input int n);
      int m;
      int v;
      m = (n < DEF_NCOEF / 2) ? n : DEF_NCOEF - 1 - n;
      v = 0;
      case (m)
         0:       v = 0;
         1:       v = 1;
         2:       v = 3;
         3:       v = 2;
         4:       v = -3;
         5:       v = -12;
         6:       v = -17;
         7:       v = -10;
         8:       v = 15;
         9:       v = 55;
         10:      v = 97;
         11:      v = 124;
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [DEF_COEF_W-1:0] rc_coefs();
      logic [DEF_COEF_W-1:0] v;
      v = '0;
      for (int n = 0; n < DEF_NCOEF; n++) begin
         v[n*DEF_S_COEF +: DEF_S_COEF] = DEF_S_COEF'(rc_tap(n));
      end
      return v;
   endfunction

   localparam logic [DEF_COEF_W-1:0] DEF_RC_COEFS = rc_coefs();

endpackage

// File: rtl/tx_poly_upsmp_mac.sv
// Combinational polyphase branch: picks h[k*OS+p] for one phase
// and sums the TAPS coefficient-by-symbol products at full precision.
module poly_branch_mac
   import tx_poly_upsmp_pkg::*;
#(
   parameter int OS     = DEF_OS,
   parameter int TAPS   = DEF_TAPS,
   parameter int S_IN   = DEF_S_IN,
   parameter int S_COEF = DEF_S_COEF,
   parameter int FASE   = $clog2(OS),
   parameter int S_OUT  = S_COEF + S_IN + $clog2(TAPS)
) (
   input  logic [OS*TAPS*S_COEF-1:0] i_coefs,
   input  logic [TAPS*S_IN-1:0]      i_sr,
   input  logic [FASE-1:0]           i_phase,
   output logic signed [S_OUT-1:0]   o_sum
);

   localparam int PW = S_IN + S_COEF;

   logic signed [S_COEF-1:0] w_coef;
   logic signed [S_IN-1:0]   w_sym;
   logic signed [PW-1:0]     w_prod;
   logic signed [S_OUT-1:0]  w_acc;

   always_comb begin
      w_coef = '0;
      w_sym  = '0;
      w_prod = '0;
      w_acc  = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_coef = i_coefs[coef_idx(k, int'(i_phase), OS)*S_COEF +: S_COEF];
         w_sym  = i_sr[k*S_IN +: S_IN];
         w_prod = PW'(w_coef) * PW'(w_sym);
         w_acc  = w_acc + S_OUT'(w_prod);
      end
   end

   assign o_sum = w_acc;

endmodule

// File: rtl/tx_poly_upsmp.sv
// Transmit polyphase upsampler: one symbol in per OS accepted ticks,
// one shaped sample out per tick, with phase index and phase-0 strobe.
module tx_poly_upsmp
   import tx_poly_upsmp_pkg::*;
#(
   parameter int OS     = DEF_OS,
   parameter int TAPS   = DEF_TAPS,
   parameter int S_IN   = DEF_S_IN,
   parameter int S_COEF = DEF_S_COEF,
   parameter int FASE   = $clog2(OS),
   parameter int S_OUT  = S_COEF + S_IN + $clog2(TAPS),
   parameter logic [OS*TAPS*S_COEF-1:0] COEFS = '0
) (
   input  logic                    clock,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_valid,
   input  logic signed [S_IN-1:0]  i_symbol,
   output logic signed [S_OUT-1:0] o_tx,
   output logic                    o_valid,
   output logic                    o_sync,
   output logic [FASE-1:0]         o_fase
);

   logic [FASE-1:0]         r_cnt;
   logic [FASE-1:0]         r_p;
   logic                    r_v1;
   logic [TAPS*S_IN-1:0]    r_sr;
   logic signed [S_OUT-1:0] r_tx;
   logic                    r_valid;
   logic                    r_sync;
   logic [FASE-1:0]         r_fase;

   logic                    w_last;
   logic signed [S_OUT-1:0] w_sum;

   assign w_last = (r_cnt == FASE'(OS - 1));

   poly_branch_mac #(
      .OS     (OS),
      .TAPS   (TAPS),
      .S_IN   (S_IN),
      .S_COEF (S_COEF),
      .FASE   (FASE),
      .S_OUT  (S_OUT)
   ) u_mac (
      .i_coefs (COEFS),
      .i_sr    (r_sr),
      .i_phase (r_p),
      .o_sum   (w_sum)
   );

   // Stage 1 tracks the phase and symbol history; stage 2 registers the MAC.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         r_cnt   <= '0;
         r_p     <= '0;
         r_v1    <= 1'b0;
         r_sr    <= '0;
         r_tx    <= '0;
         r_valid <= 1'b0;
         r_sync  <= 1'b0;
         r_fase  <= '0;
      end else if (i_enable) begin
         r_v1 <= i_valid;
         if (i_valid) begin
            if (r_cnt == '0) begin
               r_sr <= {r_sr[(TAPS-1)*S_IN-1:0], i_symbol};
            end
            r_p   <= r_cnt;
            r_cnt <= w_last ? '0 : r_cnt + FASE'(1);
         end
         r_tx    <= w_sum;
         r_valid <= r_v1;
         r_sync  <= r_v1 && (r_p == '0);
         r_fase  <= r_p;
      end
   end

   assign o_tx    = r_tx;
   assign o_valid = r_valid;
   assign o_sync  = r_sync;
   assign o_fase  = r_fase;

endmodule

// File: tb/tb_tx_poly_upsmp.sv
// Scoreboard bench for tx_poly_upsmp: three instances share stimulus,
// using a ramp, an all -128 and an all +127 coefficient set.
module tb_tx_poly_upsmp;
   import tx_poly_upsmp_pkg::*;

   localparam int OS     = DEF_OS;
   localparam int TAPS   = DEF_TAPS;
   localparam int S_IN   = DEF_S_IN;
   localparam int S_COEF = DEF_S_COEF;
   localparam int FASE   = DEF_FASE;
   localparam int S_OUT  = DEF_S_OUT;
   localparam int NC     = OS * TAPS;
   localparam int CW     = NC * S_COEF;

   function automatic logic [CW-1:0] ramp_coefs();
      logic [CW-1:0] v;
      v = '0;
      for (int n = 0; n < NC; n++) v[n*S_COEF +: S_COEF] = S_COEF'(n + 1);
      return v;
   endfunction

   function automatic logic [CW-1:0] fill_coefs(input int val);
      logic [CW-1:0] v;
      v = '0;
      for (int n = 0; n < NC; n++) v[n*S_COEF +: S_COEF] = S_COEF'(val);
      return v;
   endfunction

   localparam logic [CW-1:0] C_RAMP = ramp_coefs();
   localparam logic [CW-1:0] C_NEG  = fill_coefs(-128);
   localparam logic [CW-1:0] C_POS  = fill_coefs(127);

   logic                    clock;
   logic                    i_reset;
   logic                    i_enable;
   logic                    i_valid;
   logic signed [S_IN-1:0]  i_symbol;
   logic signed [S_OUT-1:0] o_tx, tx_n, tx_p;
   logic                    o_valid, v_n, v_p;
   logic                    o_sync, s_n, s_p;
   logic [FASE-1:0]         o_fase, f_n, f_p;

   tx_poly_upsmp #(.COEFS(C_RAMP)) dut (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
      .i_valid(i_valid), .i_symbol(i_symbol), .o_tx(o_tx),
      .o_valid(o_valid), .o_sync(o_sync), .o_fase(o_fase));

   tx_poly_upsmp #(.COEFS(C_NEG)) dut_n (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
      .i_valid(i_valid), .i_symbol(i_symbol), .o_tx(tx_n),
      .o_valid(v_n), .o_sync(s_n), .o_fase(f_n));

   tx_poly_upsmp #(.COEFS(C_POS)) dut_p (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
      .i_valid(i_valid), .i_symbol(i_symbol), .o_tx(tx_p),
      .o_valid(v_p), .o_sync(s_p), .o_fase(f_p));

   typedef struct {
      logic signed [S_OUT-1:0] tx;
      logic signed [S_OUT-1:0] txn;
      logic signed [S_OUT-1:0] txp;
      logic                    sync;
      logic [FASE-1:0]         fase;
   } samp_t;

   samp_t sb[$];
   samp_t got[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    m_cnt    = 0;
   int    m_sr[TAPS];
   logic  en_q, rst_q;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      en_q  <= i_enable;
      rst_q <= i_reset;
   end

   // A new sample exists only after an enabled, non-reset edge with o_valid.
   always @(negedge clock) begin
      if (en_q && !rst_q && o_valid) begin
         samp_t o;
         samp_t e;
         o.tx = o_tx; o.txn = tx_n; o.txp = tx_p;
         o.sync = o_sync; o.fase = o_fase;
         got.push_back(o);
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: o_valid with no pending sample, tx=%0d fase=%0d",
                     o_tx, o_fase);
         end else begin
            e = sb.pop_front();
            if (o.tx !== e.tx || o.txn !== e.txn || o.txp !== e.txp ||
                o.sync !== e.sync || o.fase !== e.fase ||
                v_n !== 1'b1 || v_p !== 1'b1 || s_n !== e.sync ||
                s_p !== e.sync || f_n !== e.fase || f_p !== e.fase) begin
               n_fail++;
               $display("FAIL sb_sample: got tx=%0d/%0d/%0d sync=%0b fase=%0d, want tx=%0d/%0d/%0d sync=%0b fase=%0d",
                        o.tx, o.txn, o.txp, o.sync, o.fase,
                        e.tx, e.txn, e.txp, e.sync, e.fase);
            end
         end
      end
   end

   task automatic tick(input logic t_en, input logic t_vld,
                       input logic signed [S_IN-1:0] t_sym, input logic t_rst);
      samp_t e;
      int a, b, c;
      i_enable = t_en;
      i_valid  = t_vld;
      i_symbol = t_sym;
      i_reset  = t_rst;
      if (t_rst) begin
         m_cnt = 0;
         for (int k = 0; k < TAPS; k++) m_sr[k] = 0;
      end else if (t_en && t_vld) begin
         if (m_cnt == 0) begin
            for (int k = TAPS - 1; k > 0; k--) m_sr[k] = m_sr[k-1];
            m_sr[0] = int'(t_sym);
         end
         a = 0; b = 0; c = 0;
         for (int k = 0; k < TAPS; k++) begin
            a += (k * OS + m_cnt + 1) * m_sr[k];
            b += -128 * m_sr[k];
            c += 127 * m_sr[k];
         end
         e.tx = S_OUT'(a); e.txn = S_OUT'(b); e.txp = S_OUT'(c);
         e.sync = (m_cnt == 0);
         e.fase = FASE'(m_cnt);
         sb.push_back(e);
         m_cnt = (m_cnt + 1) % OS;
      end
      @(posedge clock);
      #1;
      if (t_rst) sb.delete();
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, '0, 1'b1);
      tick(1'b0, 1'b1, 2'sd1, 1'b1);
      n_checks += 4;
      if (o_tx !== '0) begin
         n_fail++; $display("FAIL reset_tx: got %0d want 0", o_tx);
      end
      if (o_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %0b want 0", o_valid);
      end
      if (o_sync !== 1'b0) begin
         n_fail++; $display("FAIL reset_sync: got %0b want 0", o_sync);
      end
      if (o_fase !== '0) begin
         n_fail++; $display("FAIL reset_fase: got %0d want 0", o_fase);
      end
   endtask

   task automatic test_impulse();
      tick(1'b1, 1'b0, '0, 1'b1);
      got.delete();
      tick(1'b1, 1'b1, 2'sd1, 1'b0);
      n_checks++;
      if (o_valid !== 1'b0) begin
         n_fail++; $display("FAIL imp_latency1: o_valid got %0b want 0", o_valid);
      end
      tick(1'b1, 1'b1, '0, 1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || o_tx !== 13'sd1 || o_sync !== 1'b1) begin
         n_fail++;
         $display("FAIL imp_latency2: valid=%0b tx=%0d sync=%0b want 1/1/1",
                  o_valid, o_tx, o_sync);
      end
      for (int i = 2; i < 28; i++) tick(1'b1, 1'b1, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      n_checks++;
      if (got.size() != 28) begin
         n_fail++; $display("FAIL imp_count: got %0d samples want 28", got.size());
      end
      for (int i = 0; i < 28 && i < got.size(); i++) begin
         n_checks++;
         if (got[i].tx !== S_OUT'(i < 24 ? i + 1 : 0) ||
             got[i].sync !== (i % 4 == 0) || got[i].fase !== FASE'(i % 4)) begin
            n_fail++;
            $display("FAIL imp_seq[%0d]: tx=%0d sync=%0b fase=%0d want tx=%0d sync=%0b fase=%0d",
                     i, got[i].tx, got[i].sync, got[i].fase,
                     i < 24 ? i + 1 : 0, i % 4 == 0, i % 4);
         end
      end
   endtask

   task automatic test_steady(input logic signed [S_IN-1:0] sym,
                              input int base, input int step);
      tick(1'b1, 1'b0, '0, 1'b1);
      got.delete();
      for (int i = 0; i < 32; i++) tick(1'b1, 1'b1, sym, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      n_checks++;
      if (got.size() != 32) begin
         n_fail++; $display("FAIL steady_count: got %0d want 32", got.size());
      end
      for (int i = 20; i < 32 && i < got.size(); i++) begin
         n_checks++;
         if (got[i].tx !== S_OUT'(base + step * (i % 4))) begin
            n_fail++;
            $display("FAIL steady[%0d]: got %0d want %0d",
                     i, got[i].tx, base + step * (i % 4));
         end
      end
   endtask

   task automatic test_extremes();
      tick(1'b1, 1'b0, '0, 1'b1);
      got.delete();
      for (int i = 0; i < 32; i++) tick(1'b1, 1'b1, -2'sd2, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      for (int i = 20; i < 32 && i < got.size(); i++) begin
         n_checks++;
         if (got[i].txn !== 13'sd1536 || got[i].txp !== -13'sd1524) begin
            n_fail++;
            $display("FAIL extremes[%0d]: got %0d/%0d want 1536/-1524",
                     i, got[i].txn, got[i].txp);
         end
      end
   endtask

   task automatic test_gaps();
      tick(1'b1, 1'b0, '0, 1'b1);
      got.delete();
      for (int i = 0; i < 28; i++) begin
         tick(1'b1, 1'b1, (i == 0) ? 2'sd1 : 2'sd0, 1'b0);
         tick(1'b1, 1'b0, 2'sd1, 1'b0);
      end
      tick(1'b1, 1'b0, '0, 1'b0);
      n_checks++;
      if (got.size() != 28) begin
         n_fail++; $display("FAIL gaps_count: got %0d want 28", got.size());
      end
      for (int i = 0; i < 28 && i < got.size(); i++) begin
         n_checks++;
         if (got[i].tx !== S_OUT'(i < 24 ? i + 1 : 0) ||
             got[i].fase !== FASE'(i % 4)) begin
            n_fail++;
            $display("FAIL gaps_seq[%0d]: tx=%0d fase=%0d want tx=%0d fase=%0d",
                     i, got[i].tx, got[i].fase, i < 24 ? i + 1 : 0, i % 4);
         end
      end
   endtask

   task automatic test_freeze();
      logic signed [S_OUT-1:0] k_tx;
      logic k_v, k_s;
      logic [FASE-1:0] k_f;
      tick(1'b1, 1'b0, '0, 1'b1);
      got.delete();
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, (i == 0) ? 2'sd1 : 2'sd0, 1'b0);
      k_tx = o_tx; k_v = o_valid; k_s = o_sync; k_f = o_fase;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b1, 2'sd1, 1'b0);
         n_checks++;
         if (o_tx !== k_tx || o_valid !== k_v || o_sync !== k_s || o_fase !== k_f) begin
            n_fail++;
            $display("FAIL freeze[%0d]: tx=%0d v=%0b s=%0b f=%0d want %0d/%0b/%0b/%0d",
                     i, o_tx, o_valid, o_sync, o_fase, k_tx, k_v, k_s, k_f);
         end
      end
      for (int i = 6; i < 28; i++) tick(1'b1, 1'b1, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      n_checks++;
      if (got.size() != 28) begin
         n_fail++; $display("FAIL freeze_count: got %0d want 28", got.size());
      end
      for (int i = 0; i < 28 && i < got.size(); i++) begin
         n_checks++;
         if (got[i].tx !== S_OUT'(i < 24 ? i + 1 : 0)) begin
            n_fail++;
            $display("FAIL freeze_seq[%0d]: got %0d want %0d",
                     i, got[i].tx, i < 24 ? i + 1 : 0);
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 1'b0, '0, 1'b1);
      tick(1'b1, 1'b1, 2'sd1, 1'b0);
      tick(1'b1, 1'b1, '0, 1'b0);
      tick(1'b1, 1'b1, '0, 1'b1);
      n_checks++;
      if (o_tx !== '0 || o_valid !== 1'b0 || o_sync !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_out: tx=%0d v=%0b s=%0b want 0/0/0",
                  o_tx, o_valid, o_sync);
      end
      got.delete();
      for (int i = 0; i < 28; i++) tick(1'b1, 1'b1, (i == 0) ? -2'sd2 : 2'sd0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 28 && i < got.size(); i++) begin
         n_checks++;
         if (got[i].tx !== S_OUT'(i < 24 ? -2 * (i + 1) : 0) ||
             got[i].fase !== FASE'(i % 4)) begin
            n_fail++;
            $display("FAIL rstmid_seq[%0d]: tx=%0d fase=%0d want tx=%0d fase=%0d",
                     i, got[i].tx, got[i].fase, i < 24 ? -2 * (i + 1) : 0, i % 4);
         end
      end
   endtask

   task automatic test_random();
      int acc;
      logic en, vl;
      tick(1'b1, 1'b0, '0, 1'b1);
      got.delete();
      acc = 0;
      for (int i = 0; i < 200; i++) begin
         en = ($urandom_range(0, 9) != 0);
         vl = ($urandom_range(0, 9) < 7);
         if (en && vl) acc++;
         tick(en, vl, S_IN'($urandom_range(0, 3)), 1'b0);
      end
      tick(1'b1, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);
      n_checks += 2;
      if (got.size() != acc) begin
         n_fail++; $display("FAIL rand_count: got %0d want %0d", got.size(), acc);
      end
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL rand_drain: %0d samples never emitted want 0", sb.size());
      end
   endtask

   initial begin
      i_reset  = 1'b1;
      i_enable = 1'b0;
      i_valid  = 1'b0;
      i_symbol = '0;
      for (int k = 0; k < TAPS; k++) m_sr[k] = 0;
      test_reset();
      test_impulse();
      test_steady(2'sd1, 66, 6);
      test_steady(-2'sd2, -132, -12);
      test_extremes();
      test_gaps();
      test_freeze();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_poly_upsmp.md
Name: tx_poly_upsmp

Overview:
- Transmit-side counterpart of the receive downsampler: accepts one signed symbol every OS accepted clock ticks.
- Produces OS raised-cosine-shaped samples per symbol through a polyphase FIR with TAPS symbol-spaced taps per phase.
- Emits a sample-phase index and a one-tick sync strobe marking phase 0, which downstream channel/RX blocks use for timing.
- Sits between the PRBS/symbol mapper and the channel model.

Parameters:
- OS, 4, oversampling factor (samples per symbol).
- TAPS, 6, symbol-spaced taps per polyphase branch (filter length OS*TAPS).
- S_IN, 2, signed symbol width.
- S_COEF, 8, signed coefficient width.
- FASE, $clog2(OS), phase index width.
- S_OUT, S_COEF+S_IN+$clog2(TAPS), full-precision signed output width (13 at defaults).
- COEFS, all zero, flattened coefficient vector of OS*TAPS*S_COEF bits; h[n] occupies bits [n*S_COEF +: S_COEF].

Ports:
- clock  in  1  single system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global enable; low freezes all state.
- i_valid  in  1  sample tick; a tick is accepted when i_enable && i_valid.
- i_symbol  in  S_IN  signed symbol; sampled only on accepted ticks with cnt==0.
- o_tx  out  S_OUT  signed shaped sample.
- o_valid  out  1  o_tx is a new sample this cycle.
- o_sync  out  1  high with o_valid when o_tx is the phase-0 sample of a symbol.
- o_fase  out  FASE  phase (0..OS-1) of the current o_tx.

Behaviour:
- Reset, applied at a clock edge with i_reset=1 (takes priority over enable):
  - cnt=0, all sr[k]=0, p_reg=0, v1=0.
  - Outputs: o_tx=0, o_valid=0, o_sync=0, o_fase=0.
  - Reset mid-symbol discards history; the next accepted tick is phase 0.
- Stage 1, on an accepted tick:
  - If cnt==0: sr <= {sr[TAPS-2:0], i_symbol}. sr[0] is the newest symbol; the oldest is dropped.
  - p_reg <= cnt; v1 <= 1.
  - cnt <= (cnt==OS-1) ? 0 : cnt+1.
- Stage 1, with i_enable=1 and i_valid=0: v1 <= 0; cnt, sr and p_reg hold.
- Stage 2, when i_enable=1:
  - o_tx <= sum over k=0..TAPS-1 of h[k*OS+p_reg]*sr[k].
  - o_valid <= v1; o_sync <= v1 && (p_reg==0); o_fase <= p_reg.
- i_enable=0: every register holds, including the outputs. o_valid is held, and consumers must also qualify on i_enable.
- Latency: a symbol accepted at edge T first appears, weighted by h[0], in o_tx after edge T+1, i.e. two accepted edges after presentation.
- Arithmetic:
  - Full precision, signed; products are S_IN+S_COEF bits.
  - The sum is sign-extended to S_OUT, with no rounding and no saturation. Overflow is impossible by construction.
- Symbols are full signed S_IN range (e.g. -2..+1). A value of 0 is legal and used for impulse tests.
- Gaps in i_valid between the phases of one symbol are legal; phase continuity is preserved.

Decomposition:
- Shared package: OS, TAPS, S_IN, S_COEF, derived FASE and S_OUT, and the default COEFS vector (RC roll-off 0.5, Q(S_COEF-1)). The same package also feeds the RX downsampler and slicer.
- One natural sub-module: poly_branch_mac. It is purely combinational: it selects h[k*OS+p] for a phase and sums the TAPS products. The top holds the counter, shift register and pipeline.

Test Plan:
- Impulse: COEFS h[n]=n+1, symbols +1 then 0s, i_valid=1 continuously -> o_tx = 1,2,...,24 on consecutive o_valid cycles, then 0. o_sync is high on the values 1, 5, 9, 13, 17, 21; o_fase cycles 0,1,2,3.
- Steady state, same COEFS, all symbols +1 -> after 6 symbols, phase 0..3 outputs are 66, 72, 78, 84, repeating. Symbols all -2 -> -132, -144, -156, -168.
- Extremes: all h=-128, all symbols -2 -> o_tx=+1536 with no wrap. h=127, symbols -2 -> -1524.
- Gaps: i_valid toggling 1,0,1,0 -> o_valid pulses only after accepted ticks, and the output sequence is identical to the impulse case with no phase skipped.
- Enable freeze: drop i_enable for 5 cycles mid-symbol -> all outputs and o_fase are constant. On resume, the sequence continues exactly where it stopped.
- Reset mid-operation: assert i_reset for 1 cycle at phase 2 -> next edge o_tx=0, o_valid=0, o_sync=0. The next accepted tick loads a new symbol as phase 0, and the history is all zeros.
